// File: rtl/char_plot_engine.sv
// char_plot_engine: renders one 8x8 font glyph per request as pixel writes.
// Macro TRANSPARENT_BG_EN: 0-bits are skipped instead of drawn in req_bg.
module char_plot_engine #(
   parameter int COLS = 20,
   parameter int ROWS = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_char,
   input  logic [4:0] req_col,
   input  logic [3:0] req_row,
   input  logic [2:0] req_fg,
   input  logic [2:0] req_bg,
   output logic [9:0] font_addr,
   input  logic [7:0] font_data,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      DRAW,
      DONE
   } state_t;

   localparam logic [5:0] COLS_W = 6'(COLS);
   localparam logic [4:0] ROWS_W = 5'(ROWS);

   state_t     state;
   logic [6:0] rchar;
   logic [4:0] rcol;
   logic [3:0] rrow;
   logic [2:0] rfg;
   logic [2:0] rbg;
   logic [2:0] px;
   logic [2:0] grow;
   logic [7:0] shreg;

   logic       oor;
   logic [7:0] xbase;
   logic [6:0] ybase;
   logic       cur_bit;
   logic       pix_plot;
   logic [2:0] pix_colour;

   assign oor   = ({1'b0, req_col} >= COLS_W) ||
                  ({1'b0, req_row} >= ROWS_W);
   assign xbase = {rcol, 3'd0};
   assign ybase = {rrow, 3'd0};

   // The first pixel of a row comes straight from the ROM, later ones
   // from the pre-shifted register.
   assign cur_bit = (state == LATCH) ? font_data[7] : shreg[7];

`ifdef TRANSPARENT_BG_EN
   logic unused_bg;
   assign unused_bg  = ^rbg;
   assign pix_plot   = cur_bit;
   assign pix_colour = rfg;
`else
   assign pix_plot   = 1'b1;
   assign pix_colour = cur_bit ? rfg : rbg;
`endif

   // Request handshake, glyph row walk and registered pixel outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         plot      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         px        <= 3'd0;
         grow      <= 3'd0;
         font_addr <= 10'd0;
         shreg     <= 8'd0;
         x         <= 8'd0;
         y         <= 7'd0;
         colour    <= 3'd0;
         rchar     <= 7'd0;
         rcol      <= 5'd0;
         rrow      <= 4'd0;
         rfg       <= 3'd0;
         rbg       <= 3'd0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  rchar     <= req_char;
                  rcol      <= req_col;
                  rrow      <= req_row;
                  rfg       <= req_fg;
                  rbg       <= req_bg;
                  req_ready <= 1'b0;
                  grow      <= 3'd0;
                  px        <= 3'd0;
                  if (oor) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state     <= FETCH;
                     font_addr <= {req_char, 3'd0};
                  end
               end
            end
            FETCH: begin
               state <= LATCH;
            end
            LATCH: begin
               shreg  <= {font_data[6:0], 1'b0};
               px     <= 3'd0;
               x      <= xbase;
               y      <= ybase + {4'd0, grow};
               plot   <= pix_plot;
               colour <= pix_colour;
               state  <= DRAW;
            end
            DRAW: begin
               px <= px + 3'd1;
               if (px == 3'd7) begin
                  grow <= grow + 3'd1;
                  if (grow == 3'd7) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     font_addr <= {rchar, grow + 3'd1};
                     state     <= FETCH;
                  end
               end else begin
                  shreg  <= {shreg[6:0], 1'b0};
                  x      <= xbase + {5'd0, px + 3'd1};
                  plot   <= pix_plot;
                  colour <= pix_colour;
               end
            end
            DONE: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_char_plot_engine.sv
// tb_char_plot_engine: directed and random glyph requests checked against
// a pixel-list model driven by a registered font ROM model.
`timescale 1ns/1ps
module tb_char_plot_engine;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [6:0] req_char;
   logic [4:0] req_col;
   logic [3:0] req_row;
   logic [2:0] req_fg;
   logic [2:0] req_bg;
   logic [9:0] font_addr;
   logic [7:0] font_data;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       done;
   logic       err;

   int n_err = 0;
   int n_chk = 0;

   logic       rom_fixed;
   logic [7:0] rom_val;

   typedef struct {
      int cyc;
      int px_x;
      int px_y;
      int col;
   } pix_t;

   pix_t expq[$];

   char_plot_engine dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_char (req_char),
      .req_col  (req_col),
      .req_row  (req_row),
      .req_fg   (req_fg),
      .req_bg   (req_bg),
      .font_addr(font_addr),
      .font_data(font_data),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .plot     (plot),
      .done     (done),
      .err      (err)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] rom_fn(input logic [9:0] a);
      int v;
      if (rom_fixed) return rom_val;
      v = int'(a) * 37 + 11;
      return 8'(v ^ (v >> 4));
   endfunction

   // Font ROM with one cycle of read latency
   always @(posedge clock) font_data <= rom_fn(font_addr);

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected pixel list: 8 rows of 10 cycles, plots on cycles 3..10.
   task automatic build(input int ch, input int col, input int row,
                        input int fg, input int bg);
      logic [7:0] d;
      logic       b;
      expq.delete();
      for (int gr = 0; gr < 8; gr++) begin
         d = rom_fn(10'(ch * 8 + gr));
         for (int p = 0; p < 8; p++) begin
            b = d[7 - p];
`ifdef TRANSPARENT_BG_EN
            if (b)
               expq.push_back('{10 * gr + 3 + p, col * 8 + p,
                                row * 8 + gr, fg});
`else
            expq.push_back('{10 * gr + 3 + p, col * 8 + p,
                             row * 8 + gr, b ? fg : bg});
`endif
         end
      end
   endtask

   // Called at a negedge; request is accepted at the following posedge.
   task automatic start(input int ch, input int col, input int row,
                        input int fg, input int bg, input bit hold,
                        input int hold_ch);
      check("ready_pre", req_ready, 1);
      req_valid = 1'b1;
      req_char  = 7'(ch);
      req_col   = 5'(col);
      req_row   = 4'(row);
      req_fg    = 3'(fg);
      req_bg    = 3'(bg);
      @(posedge clock);
      #1;
      if (hold) req_char = 7'(hold_ch);
      else req_valid = 1'b0;
   endtask

   task automatic collect(input int ch, input int col, input int row,
                          input int fg, input int bg);
      bit oor;
      bit got_done;
      int idx;
      int cyc;
      oor      = (col >= 20) || (row >= 15);
      got_done = 0;
      idx      = 0;
      cyc      = 0;
      if (oor) expq.delete();
      else build(ch, col, row, fg, bg);
      while (!got_done && cyc < 120) begin
         @(negedge clock);
         cyc++;
         if (!oor && (cyc % 10 == 1) && cyc < 80)
            check("font_addr", font_addr, ch * 8 + (cyc - 1) / 10);
         if (plot) begin
            if (idx < expq.size()) begin
               check("plot_cycle", cyc, expq[idx].cyc);
               check("x", x, expq[idx].px_x);
               check("y", y, expq[idx].px_y);
               check("colour", colour, expq[idx].col);
            end
            idx++;
         end
         if (done) begin
            got_done = 1;
            check("done_cycle", cyc, oor ? 1 : 81);
            check("err", err, oor ? 1 : 0);
            check("done_noplot", plot, 0);
         end
      end
      check("done_seen", got_done, 1);
      check("plot_count", idx, expq.size());
      @(negedge clock);
      check("ready_after", req_ready, 1);
      check("idle_noplot", plot, 0);
      check("idle_nodone", done, 0);
   endtask

   initial begin
      int cnt;
      int quiet;
      int ch;
      int col;
      int row;
      int fg;
      int bg;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_char  = '0;
      req_col   = '0;
      req_row   = '0;
      req_fg    = '0;
      req_bg    = '0;
      rom_fixed = 1'b1;
      rom_val   = 8'hFF;

      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_ready", req_ready, 1);
      check("rst_plot", plot, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);

      // Solid glyph at the origin
      start(8'h41, 0, 0, 7, 0, 0, 0);
      collect(8'h41, 0, 0, 7, 0);

      // Bottom-right corner, edge-only pattern
      rom_val = 8'h81;
      start(8'h5A, 19, 14, 5, 2, 0, 0);
      collect(8'h5A, 19, 14, 5, 2);

      // Out of range column, then row
      start(8'h30, 20, 3, 1, 2, 0, 0);
      collect(8'h30, 20, 3, 1, 2);
      start(8'h31, 4, 15, 1, 2, 0, 0);
      collect(8'h31, 4, 15, 1, 2);

      // Low-nibble glyph
      rom_val = 8'h0F;
      start(8'h07, 3, 2, 6, 1, 0, 0);
      collect(8'h07, 3, 2, 6, 1);

      // Request held high while busy with a different char
      rom_fixed = 1'b0;
      start(8'h10, 5, 6, 3, 4, 1, 8'h22);
      collect(8'h10, 5, 6, 3, 4);
      start(8'h22, 5, 6, 3, 4, 0, 0);
      collect(8'h22, 5, 6, 3, 4);

      // Random requests, some out of range
      for (int i = 0; i < 8; i++) begin
         ch  = int'($urandom_range(0, 127));
         col = int'($urandom_range(0, 21));
         row = int'($urandom_range(0, 16));
         fg  = int'($urandom_range(0, 7));
         bg  = int'($urandom_range(0, 7));
         start(ch, col, row, fg, bg, 0, 0);
         collect(ch, col, row, fg, bg);
      end

      // Reset wins over a simultaneous request
      reset     = 1'b1;
      req_valid = 1'b1;
      req_char  = 7'h12;
      req_col   = 5'd1;
      req_row   = 4'd1;
      @(negedge clock);
      reset     = 1'b0;
      req_valid = 1'b0;
      check("rst_prio_ready", req_ready, 1);
      quiet = 0;
      repeat (12) begin
         @(negedge clock);
         if (plot || done) quiet++;
      end
      check("rst_prio_quiet", quiet, 0);

      // Reset at the 30th plot abandons the character
      rom_fixed = 1'b1;
      rom_val   = 8'h0F;
      start(8'h44, 7, 7, 2, 5, 0, 0);
      cnt = 0;
      for (int i = 0; i < 100 && cnt < 30; i++) begin
         @(negedge clock);
         if (plot) cnt++;
      end
      check("reach_30", cnt, 30);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst_mid_plot", plot, 0);
      check("rst_mid_done", done, 0);
      quiet = 0;
      repeat (100) begin
         @(negedge clock);
         if (plot || done) quiet++;
      end
      check("rst_mid_quiet", quiet, 0);
      check("rst_mid_ready", req_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
